// File: rtl/sensor_window_sched.sv
// Round-robin sample scheduler feeding the four-channel fault detector: admits a fixed
// quota per channel per window, sequences baseline then monitor windows, and flags stalls.
module sensor_window_sched #(
  parameter int SAMPLES_PER_WIN = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  ch_req,
  input  logic [31:0] ch_data,
  output logic [3:0]  ch_ack,
  output logic        det_valid,
  output logic [1:0]  det_check,
  output logic [7:0]  det_data,
  output logic        det_clr,
  output logic [1:0]  phase,
  output logic        base_done,
  output logic        win_done,
  output logic        abort,
  output logic [3:0]  stall,
  output logic [7:0]  win_count
);

  localparam logic [1:0]  PH_IDLE   = 2'd0;
  localparam logic [1:0]  PH_BASE   = 2'd1;
  localparam logic [1:0]  PH_MON    = 2'd2;
  localparam logic [3:0]  QUOTA_MAX = 4'(SAMPLES_PER_WIN);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  logic [1:0]  rr_ptr;
  logic [3:0]  quota [4];
  logic [15:0] tmo_cnt;

  logic        active;
  logic [3:0]  under;
  logic [3:0]  elig;
  logic [3:0]  win_full;
  logic [2:0]  pick;
  logic        grant_any;
  logic [1:0]  grant_idx;
  logic        complete;
  logic        timeout_hit;
  logic        grant;

  // Lowest offset from the pointer wins; the descending loop lets it overwrite last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    active   = (phase == PH_BASE) || (phase == PH_MON);
    under    = '0;
    elig     = '0;
    for (int i = 0; i < 4; i++) begin
      under[i] = (quota[i] < QUOTA_MAX);
      elig[i]  = en && active && ch_req[i] && under[i] && !ch_ack[i];
    end
  end

  assign pick      = rr_pick(elig, rr_ptr);
  assign grant_any = pick[2];
  assign grant_idx = pick[1:0];

  // A window is complete if every quota is full once this cycle's grant is counted.
  always_comb begin
    win_full = '0;
    for (int i = 0; i < 4; i++) begin
      win_full[i] = (quota[i] == QUOTA_MAX) ||
                    (grant_any && (grant_idx == 2'(i)) && (quota[i] == QUOTA_MAX - 4'd1));
    end
  end

  assign complete    = en && active && (&win_full);
  assign timeout_hit = en && active && !complete && (tmo_cnt == TMO_LAST);
  assign grant       = grant_any && !timeout_hit;

  // Grant path: registered handshake and detector sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ack    <= '0;
      det_valid <= 1'b0;
      det_check <= '0;
      det_data  <= '0;
      rr_ptr    <= '0;
    end else begin
      ch_ack    <= '0;
      det_valid <= 1'b0;
      if (grant) begin
        ch_ack    <= 4'b0001 << grant_idx;
        det_valid <= 1'b1;
        det_check <= grant_idx;
        det_data  <= ch_data[{grant_idx, 3'b000} +: 8];
        rr_ptr    <= grant_idx + 2'd1;
      end
    end
  end

  // Window sequencing: phase, timeout, completion and stall tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PH_IDLE;
      det_clr   <= 1'b0;
      base_done <= 1'b0;
      win_done  <= 1'b0;
      abort     <= 1'b0;
      stall     <= '0;
      win_count <= '0;
      tmo_cnt   <= '0;
    end else begin
      det_clr   <= 1'b0;
      base_done <= 1'b0;
      win_done  <= 1'b0;
      abort     <= 1'b0;
      if (!en) begin
        phase   <= PH_IDLE;
        tmo_cnt <= '0;
      end else if (phase == PH_IDLE) begin
        phase   <= PH_BASE;
        det_clr <= 1'b1;
        tmo_cnt <= '0;
      end else if (!active) begin
        phase   <= PH_IDLE;
        tmo_cnt <= '0;
      end else if (complete) begin
        tmo_cnt <= '0;
        stall   <= '0;
        if (phase == PH_BASE) begin
          base_done <= 1'b1;
          phase     <= PH_MON;
        end else begin
          win_done  <= 1'b1;
          win_count <= win_count + 8'd1;
        end
      end else if (timeout_hit) begin
        // Retry the same window: the detector is cleared and the phase is kept.
        abort   <= 1'b1;
        det_clr <= 1'b1;
        stall   <= stall | under;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) quota[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!en || !active || complete || timeout_hit) begin
          quota[i] <= '0;
        end else if (grant && (grant_idx == 2'(i))) begin
          quota[i] <= quota[i] + 4'd1;
        end
      end
    end
  end

endmodule

// File: doc/sensor_window_sched.md
Name: sensor_window_sched

Overview:
- Round-robin scheduler that feeds the four-channel fault detector from four independent sensor requesters.
- Admits exactly SAMPLES_PER_WIN samples per channel per window and drives the detector's 8-bit sample and 2-bit channel select.
- Sequences a baseline window followed by repeated monitor windows.
- Flags channels that stall a window past a timeout.

Parameters:
- SAMPLES_PER_WIN, 4: samples accepted per channel per window; range 1..15.
- TIMEOUT, 255: cycles allowed per window before abort; range 1..65535.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable.
- ch_req  in  4  per-channel sample request; held until acked.
- ch_data  in  32  channel i sample on bits [8i+7:8i].
- ch_ack  out  4  one-cycle acknowledge to the granted channel.
- det_valid  out  1  sample strobe to the detector.
- det_check  out  2  channel index of the sample.
- det_data  out  8  sample value.
- det_clr  out  1  one-cycle pulse; detector clears its accumulators.
- phase  out  2  0 IDLE, 1 BASE, 2 MON.
- base_done  out  1  one-cycle pulse when the baseline window completes.
- win_done  out  1  one-cycle pulse when a monitor window completes.
- abort  out  1  one-cycle pulse when a window times out.
- stall  out  4  sticky per-channel timeout flags.
- win_count  out  8  completed monitor windows; wraps.

Behaviour:
- Reset (async, rst_n low) values:
  - all outputs 0, phase IDLE;
  - RR pointer 0;
  - quota counters, timeout counter, stall and win_count cleared.
- States:
  - IDLE -> BASE when en=1; det_clr pulses in the first cycle of BASE.
  - BASE -> MON on baseline completion.
  - MON -> MON on each completion.
  - Any state -> IDLE the cycle after en=0. The partial window is discarded, quota counters clear, and no done pulse is issued.
- Eligibility: ch_req[i]=1, quota[i] < SAMPLES_PER_WIN, ch_ack[i]=0 this cycle, and phase is BASE or MON.
- Arbitration:
  - at most one grant per cycle;
  - search starts at the RR pointer and ascends mod 4;
  - after a grant to channel i, pointer = (i+1) mod 4; pointer is unchanged if no grant.
- Grant (all registered, visible the cycle after the decision edge):
  - ch_ack[i]=1, det_valid=1, det_check=i;
  - det_data = ch_data[i] sampled at the decision edge;
  - quota[i] increments.
- Requester handshake: the requester sees ack high and must present its next sample or drop req in that same cycle. Latency from req assertion to ack is 1 cycle when uncontended, at most 4 cycles when all channels contend.
- Completion (all quotas = SAMPLES_PER_WIN), registered pulses on the next cycle:
  - base_done in BASE, or win_done in MON (win_count +1, 255 -> 0);
  - det_clr=0 for base completion, so the detector keeps its baseline;
  - quotas and the timeout counter clear;
  - stall clears;
  - the new window begins the following cycle.
- Timeout:
  - the counter increments each cycle in BASE or MON while the window is incomplete;
  - on reaching TIMEOUT: abort pulses, stall[i] is set for every channel with quota < SAMPLES_PER_WIN, quotas clear, det_clr pulses, and phase stays unchanged (the window retries);
  - stall remains set across retries until a window completes.
- Simultaneous events:
  - the grant completing the last quota on the same cycle the timeout is reached counts as completion; no abort;
  - en=0 takes priority over completion and timeout.
- Output behaviour:
  - det_valid, ch_ack, det_clr, base_done, win_done and abort are never high for more than one consecutive cycle per event;
  - det_data and det_check hold their last values when det_valid=0.

Test Plan:
1. Reset, en=1, ch_req=4'b0001, ch_data[7:0]=8'h10, SAMPLES_PER_WIN=4 -> det_clr pulses 1 cycle after en. Then 4 acks to ch0 with det_check=0 and det_data=8'h10, spaced by at least 1 cycle. No base_done, since ch1-3 are idle.
2. All four ch_req held high, distinct data 8'h11/22/33/44 -> grants cycle 0,1,2,3,0,... with det_check following that order. After the 16th grant, base_done pulses 1 cycle later and phase=2.
3. Continue in MON with all channels requesting -> win_done pulses after every 16 grants. win_count increments; after 256 windows it reads 0.
4. TIMEOUT=40, ch2 never requests, others always request -> abort at cycle 40 of the window, stall=4'b0100, det_clr pulses and phase is unchanged. When ch2 resumes, the window completes and stall clears.
5. en dropped mid-BASE after 5 grants -> phase=0 next cycle with no done or abort pulse. Re-enabling gives det_clr and a fresh window with quotas at 0.
6. rst_n pulsed low mid-MON with ch_ack high -> all outputs 0 immediately (asynchronous). After release, the first grant goes to ch0.
